// File: rtl/spike_vote_counter.sv
// Spike vote counter: accumulates per-class spike counts over a programmed
// number of iterations, then scans for the winning class. Optional port via VOTE_COUNTS_EN.
module spike_vote_counter #(
  parameter int NUM_CLASSES = 10,
  parameter int CLASS_W     = 4,
  parameter int COUNT_W     = 8,
  parameter int ITER_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ITER_W-1:0]  iteration_num,
  input  logic               spike_valid,
  input  logic [CLASS_W-1:0] spike_class,
  input  logic               spike,
  input  logic               iteration_done,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ack,
  output logic [CLASS_W-1:0] result_class,
  output logic [COUNT_W-1:0] result_count,
  output logic               tie,
  output logic               class_err
`ifdef VOTE_COUNTS_EN
  ,
  output logic [NUM_CLASSES*COUNT_W-1:0] counts_flat
`endif
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [COUNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [ITER_W-1:0]  target_q, target_d;
  logic [CLASS_W-1:0] idx_q, idx_d;
  logic [CLASS_W-1:0] arg_q, arg_d;
  logic [COUNT_W-1:0] max_q, max_d;
  logic               tieWork_q, tieWork_d;
  logic [CLASS_W-1:0] resClass_q, resClass_d;
  logic [COUNT_W-1:0] resCount_q, resCount_d;
  logic               resTie_q, resTie_d;
  logic               err_q, err_d;

  logic               canCount;
  logic               classOk;
  logic [COUNT_W-1:0] scanVal;

  // Once the final iteration is tallied, COUNT spends one settle cycle with
  // iter_q == target_q before entering SCAN; inputs in that cycle are ignored.
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    target_d   = target_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    max_d      = max_q;
    tieWork_d  = tieWork_q;
    resClass_d = resClass_q;
    resCount_d = resCount_q;
    resTie_d   = resTie_q;
    err_d      = err_q;
    for (int k = 0; k < NUM_CLASSES; k++) cnt_d[k] = cnt_q[k];

    canCount = (state_q == COUNT) && (iter_q != target_q);
    classOk  = 1'b0;
    scanVal  = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (spike_class == CLASS_W'(k)) classOk = 1'b1;
      if (idx_q == CLASS_W'(k)) scanVal = cnt_q[k];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = (iteration_num == '0) ? ITER_W'(1) : iteration_num;
          iter_d   = '0;
          err_d    = 1'b0;
          for (int k = 0; k < NUM_CLASSES; k++) cnt_d[k] = '0;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (canCount) begin
          if (spike_valid && !classOk) err_d = 1'b1;
          for (int k = 0; k < NUM_CLASSES; k++) begin
            if (spike_valid && spike && spike_class == CLASS_W'(k) && cnt_q[k] != '1)
              cnt_d[k] = cnt_q[k] + COUNT_W'(1);
          end
          if (iteration_done) iter_d = iter_q + ITER_W'(1);
        end else begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Strictly-greater update keeps the lowest index among equal counts.
        if (idx_q == '0) begin
          max_d     = scanVal;
          arg_d     = '0;
          tieWork_d = 1'b0;
        end else if (scanVal > max_q) begin
          max_d     = scanVal;
          arg_d     = idx_q;
          tieWork_d = 1'b0;
        end else if (scanVal == max_q) begin
          tieWork_d = 1'b1;
        end
        idx_d = idx_q + CLASS_W'(1);
        if (idx_q == CLASS_W'(NUM_CLASSES - 1)) begin
          resClass_d = arg_d;
          resCount_d = max_d;
          resTie_d   = tieWork_d;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      target_q   <= '0;
      idx_q      <= '0;
      arg_q      <= '0;
      max_q      <= '0;
      tieWork_q  <= 1'b0;
      resClass_q <= '0;
      resCount_q <= '0;
      resTie_q   <= 1'b0;
      err_q      <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      target_q   <= target_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      max_q      <= max_d;
      tieWork_q  <= tieWork_d;
      resClass_q <= resClass_d;
      resCount_q <= resCount_d;
      resTie_q   <= resTie_d;
      err_q      <= err_d;
      for (int k = 0; k < NUM_CLASSES; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign busy         = (state_q == COUNT) || (state_q == SCAN);
  assign result_valid = (state_q == HOLD);
  assign result_class = resClass_q;
  assign result_count = resCount_q;
  assign tie          = resTie_q;
  assign class_err    = err_q;

`ifdef VOTE_COUNTS_EN
  always_comb begin
    counts_flat = '0;
    for (int k = 0; k < NUM_CLASSES; k++) counts_flat[k*COUNT_W +: COUNT_W] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_spike_vote_counter.sv
// Scoreboard bench for spike_vote_counter: stimulus pushes expected results,
// a negedge monitor pops and compares each time result_valid rises.
module tb_spike_vote_counter;

  localparam int NUM_CLASSES = 10;
  localparam int CLASS_W     = 4;
  localparam int COUNT_W     = 4;
  localparam int ITER_W      = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [ITER_W-1:0]  iteration_num = '0;
  logic               spike_valid = 1'b0;
  logic [CLASS_W-1:0] spike_class = '0;
  logic               spike = 1'b0;
  logic               iteration_done = 1'b0;
  logic               busy;
  logic               result_valid;
  logic               result_ack = 1'b0;
  logic [CLASS_W-1:0] result_class;
  logic [COUNT_W-1:0] result_count;
  logic               tie;
  logic               class_err;
`ifdef VOTE_COUNTS_EN
  logic [NUM_CLASSES*COUNT_W-1:0] counts_flat;
`endif

  spike_vote_counter #(
    .NUM_CLASSES(NUM_CLASSES), .CLASS_W(CLASS_W), .COUNT_W(COUNT_W), .ITER_W(ITER_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .iteration_num(iteration_num),
    .spike_valid(spike_valid), .spike_class(spike_class), .spike(spike),
    .iteration_done(iteration_done), .busy(busy), .result_valid(result_valid),
    .result_ack(result_ack), .result_class(result_class), .result_count(result_count),
    .tie(tie), .class_err(class_err)
`ifdef VOTE_COUNTS_EN
    , .counts_flat(counts_flat)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int cls;
    int cnt;
    int tie;
  } exp_t;

  exp_t sbQ[$];
  int   compared = 0;
  int   mismatched = 0;
  logic prevValid = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: compare the scoreboard head on each rising result_valid.
  always @(negedge clock) begin
    if (result_valid && !prevValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("result_class", int'(result_class), e.cls);
        checkOutput("result_count", int'(result_count), e.cnt);
        checkOutput("tie", int'(tie), e.tie);
      end
    end
    prevValid = result_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doStart(input int n);
    start = 1'b1;
    iteration_num = ITER_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int cls, input bit endIter);
    spike_valid = 1'b1;
    spike_class = CLASS_W'(cls);
    spike = 1'b1;
    iteration_done = endIter;
    tick();
    spike_valid = 1'b0;
    spike = 1'b0;
    iteration_done = 1'b0;
  endtask

  task automatic iterDone();
    iteration_done = 1'b1;
    tick();
    iteration_done = 1'b0;
  endtask

  // Counts cycles after the final iteration_done until result_valid, then acks.
  task automatic waitResult(input string name, input bit doAck);
    int cycles = 0;
    while (!result_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    checkOutput(name, cycles, NUM_CLASSES + 1);
    if (doAck) begin
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
    end
  endtask

  task automatic pushExp(input int c, input int n, input int t);
    exp_t e;
    e.cls = c;
    e.cnt = n;
    e.tie = t;
    sbQ.push_back(e);
  endtask

  initial begin
    repeat (3) tick();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(result_valid), 0);
    checkOutput("rst_class", int'(result_class), 0);
    checkOutput("rst_count", int'(result_count), 0);
    checkOutput("rst_tie", int'(tie), 0);
    checkOutput("rst_err", int'(class_err), 0);
    reset = 1'b1;
    tick();

    // Single-iteration winner on class 7.
    doStart(1);
    checkOutput("busy_count", int'(busy), 1);
    applyStimulus(7, 1'b0);
    pushExp(7, 1, 0);
    iterDone();
    waitResult("latency_t1", 1'b1);
    tick();
    checkOutput("t1_valid_drop", int'(result_valid), 0);
    checkOutput("t1_idle_busy", int'(busy), 0);
    checkOutput("t1_class_kept", int'(result_class), 7);

    // Classes 2 and 5 tie over 10 iterations; stray start and bad class injected.
    doStart(10);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2, 1'b0);
      if (i == 4) doStart(1);
      if (i == 6) applyStimulus(12, 1'b0);
      applyStimulus(5, 1'b0);
      if (i == 9) pushExp(2, 10, 1);
      iterDone();
    end
    checkOutput("class_err_set", int'(class_err), 1);
    waitResult("latency_t2", 1'b0);
    for (int i = 0; i < 5; i++) begin
      repeat (10) tick();
      checkOutput("hold_valid", int'(result_valid), 1);
      checkOutput("hold_class", int'(result_class), 2);
      checkOutput("hold_count", int'(result_count), 10);
      checkOutput("hold_tie", int'(tie), 1);
    end
    checkOutput("hold_err", int'(class_err), 1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;

    // Saturation at 15 with 20 iterations on class 3.
    doStart(20);
    checkOutput("err_cleared", int'(class_err), 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 0) applyStimulus(1, 1'b0);
      if (i == 19) pushExp(3, 15, 0);
      applyStimulus(3, 1'b1);
    end
    waitResult("latency_t3", 1'b1);

    // iteration_num=0 acts as 1; final spike shares the cycle with iteration_done.
    doStart(0);
    result_ack = 1'b1;
    applyStimulus(0, 1'b0);
    result_ack = 1'b0;
    applyStimulus(0, 1'b0);
    applyStimulus(9, 1'b0);
    applyStimulus(9, 1'b0);
    pushExp(9, 3, 0);
    applyStimulus(9, 1'b1);
    waitResult("latency_t4", 1'b1);

    // Reset mid-count discards everything.
    doStart(10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6, 1'b0);
      applyStimulus(6, 1'b1);
    end
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_class", int'(result_class), 0);
    checkOutput("midrst_count", int'(result_count), 0);
    doStart(1);
    applyStimulus(4, 1'b0);
    pushExp(4, 1, 0);
    iterDone();
    waitResult("latency_t5", 1'b1);

    tick();
    checkOutput("sb_drained", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
